// File: rtl/cam_capture.sv
// cam_capture: Y8 camera capture front end; skips SKIP_FRAMES frames after reset, then forwards
// an H_RES x V_RES window per frame and flags each forwarded frame's geometry as ok or bad.
module cam_capture #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SKIP_FRAMES = 2
) (
    input  logic       iclk,
    input  logic       irst_n,
    input  logic       ivsync,
    input  logic       ihref,
    input  logic [7:0] ipixdata,
    output logic       ovs,
    output logic       ode,
    output logic [7:0] odata,
    output logic       oframe_ok,
    output logic       oframe_err,
    output logic       ostreaming
);
    typedef enum logic [1:0] {WAIT_VS, SKIP, STREAM} state_t;

    state_t      state_q, state_d;
    logic        vs1_q, vs1_d, hr1_q, hr1_d, act_q, act_d;
    logic [7:0]  pd1_q, pd1_d, odata_q, odata_d;
    logic        ovs_q, ovs_d, ode_q, ode_d, ok_q, ok_d, err_q, err_d, lerr_q, lerr_d;
    logic [10:0] pix_q, pix_d;
    logic [9:0]  line_q, line_d;
    logic [3:0]  skip_q, skip_d;
    logic        act, fs, fe, fall, pass;

    always_comb begin
        vs1_d   = ivsync;
        hr1_d   = ihref;
        pd1_d   = ipixdata;
        // href during vertical blanking is ignored entirely
        act     = hr1_q & ~vs1_q;
        act_d   = act;
        // ovs_q is stage-1 vsync one cycle older, so it doubles as the edge reference
        fs      = ovs_q & ~vs1_q;
        fe      = ~ovs_q & vs1_q;
        fall    = act_q & ~act;
        pix_d   = act ? ((pix_q == 11'h7ff) ? pix_q : pix_q + 11'd1) : (fall ? 11'd0 : pix_q);
        line_d  = fs ? 10'd0 : ((fall && line_q != 10'h3ff) ? line_q + 10'd1 : line_q);
        lerr_d  = fs ? 1'b0 : ((fall && pix_q != 11'(H_RES)) ? 1'b1 : lerr_q);
        pass    = (state_q == STREAM) && act && (pix_q < 11'(H_RES)) && (line_q < 10'(V_RES));
        ode_d   = pass;
        odata_d = pass ? pd1_q : 8'h00;
        ovs_d   = vs1_q;
        // act_q high at frame end means the frame was cut mid-line
        ok_d    = (state_q == STREAM) && fe && !act_q && (line_q == 10'(V_RES)) && !lerr_q;
        err_d   = (state_q == STREAM) && fe && !ok_d;
        state_d = state_q;
        skip_d  = skip_q;
        case (state_q)
            WAIT_VS: if (fe) begin
                skip_d  = 4'd0;
                state_d = (SKIP_FRAMES == 0) ? STREAM : SKIP;
            end
            SKIP: if (fe) begin
                skip_d  = skip_q + 4'd1;
                state_d = (skip_q + 4'd1 == 4'(SKIP_FRAMES)) ? STREAM : SKIP;
            end
            STREAM:  state_d = STREAM;
            default: state_d = WAIT_VS;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= WAIT_VS;
            vs1_q   <= 1'b0;
            hr1_q   <= 1'b0;
            act_q   <= 1'b0;
            pd1_q   <= 8'h00;
            odata_q <= 8'h00;
            ovs_q   <= 1'b0;
            ode_q   <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            lerr_q  <= 1'b0;
            pix_q   <= 11'd0;
            line_q  <= 10'd0;
            skip_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            vs1_q   <= vs1_d;
            hr1_q   <= hr1_d;
            act_q   <= act_d;
            pd1_q   <= pd1_d;
            odata_q <= odata_d;
            ovs_q   <= ovs_d;
            ode_q   <= ode_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            lerr_q  <= lerr_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            skip_q  <= skip_d;
        end
    end

    assign ovs        = ovs_q;
    assign ode        = ode_q;
    assign odata      = odata_q;
    assign oframe_ok  = ok_q;
    assign oframe_err = err_q;
    assign ostreaming = (state_q == STREAM);
endmodule
